// File: rtl/clk_wiz_reset_sequencer.sv
// clk_wiz_reset_sequencer
// Pulses the clock wizard's active-low reset, waits for a stable lock, then
// releases the system reset. Lost lock re-sequences the wizard; repeated lock
// timeouts park the block in a sticky error state until reset or soft request.

module clk_wiz_reset_sequencer #(
    parameter int WIZ_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 64,
    parameter int LOCK_TIMEOUT_CYCLES = 4096,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                               clk_in1,
    input  logic                               reset,
    input  logic                               locked,
    input  logic                               soft_reset_req,
    output logic                               wiz_resetn,
    output logic                               sys_reset,
    output logic                               ready,
    output logic                               error,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
    output logic [1:0]                         state
);

    // Counter widths; the stable counter needs at least one bit even when a
    // single lock cycle is enough.
    localparam int PULSE_W   = $clog2(WIZ_RST_CYCLES);
    localparam int STABLE_W  = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam int TIMEOUT_W = $clog2(LOCK_TIMEOUT_CYCLES);
    localparam int RETRY_W   = $clog2(MAX_RETRIES+1);

    localparam logic [PULSE_W-1:0]   PULSE_LAST   = PULSE_W'(WIZ_RST_CYCLES - 1);
    localparam logic [STABLE_W-1:0]  STABLE_LAST  = STABLE_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0]   RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    // Debug-visible state encoding.
    localparam logic [1:0] ST_WIZ_RST   = 2'd0;
    localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
    localparam logic [1:0] ST_RUN       = 2'd2;
    localparam logic [1:0] ST_FAIL      = 2'd3;

    logic [1:0]           sync_q,        sync_d;
    logic                 locked_s;
    logic [1:0]           state_q,       state_d;
    logic [PULSE_W-1:0]   pulse_cnt_q,   pulse_cnt_d;
    logic [STABLE_W-1:0]  stable_cnt_q,  stable_cnt_d;
    logic [TIMEOUT_W-1:0] timeout_cnt_q, timeout_cnt_d;
    logic [RETRY_W-1:0]   retry_q,       retry_d;
    logic                 wiz_resetn_q,  wiz_resetn_d;
    logic                 sys_reset_q,   sys_reset_d;
    logic                 ready_q,       ready_d;
    logic                 error_q,       error_d;

    // Two-flop synchronizer for the asynchronous lock indication.
    always_comb begin
        sync_d = {sync_q[0], locked};
    end

    assign locked_s = sync_q[1];

    // Next-state and counter logic; soft request pre-empts every transition.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        pulse_cnt_d   = pulse_cnt_q;
        stable_cnt_d  = stable_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        retry_d       = retry_q;

        if (soft_reset_req) begin
            state_d       = ST_WIZ_RST;
            pulse_cnt_d   = '0;
            stable_cnt_d  = '0;
            timeout_cnt_d = '0;
            retry_d       = '0;
        end else begin
            case (state_q)
                ST_WIZ_RST: begin
                    if (pulse_cnt_q == PULSE_LAST) begin
                        state_d       = ST_WAIT_LOCK;
                        pulse_cnt_d   = '0;
                        stable_cnt_d  = '0;
                        timeout_cnt_d = '0;
                    end else begin
                        pulse_cnt_d = pulse_cnt_q + PULSE_W'(1);
                    end
                end

                ST_WAIT_LOCK: begin
                    stable_cnt_d  = locked_s ? stable_cnt_q + STABLE_W'(1) : '0;
                    timeout_cnt_d = timeout_cnt_q + TIMEOUT_W'(1);
                    // Lock completion is checked first so it wins a tie with
                    // the timeout on the same cycle.
                    if (locked_s && (stable_cnt_q == STABLE_LAST)) begin
                        state_d       = ST_RUN;
                        retry_d       = '0;
                        stable_cnt_d  = '0;
                        timeout_cnt_d = '0;
                    end else if (timeout_cnt_q == TIMEOUT_LAST) begin
                        stable_cnt_d  = '0;
                        timeout_cnt_d = '0;
                        if (retry_q == RETRY_LIMIT) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d     = ST_WIZ_RST;
                            retry_d     = retry_q + RETRY_W'(1);
                            pulse_cnt_d = '0;
                        end
                    end
                end

                ST_RUN: begin
                    if (!locked_s) begin
                        state_d     = ST_WIZ_RST;
                        pulse_cnt_d = '0;
                    end
                end

                ST_FAIL: begin
                    state_d = ST_FAIL;
                end

                default: begin
                    state_d = ST_WIZ_RST;
                end
            endcase
        end
    end

    // Output decode of the next state, so registered outputs move with state.
    always_comb begin
        wiz_resetn_d = (state_d == ST_WAIT_LOCK) || (state_d == ST_RUN);
        sys_reset_d  = (state_d != ST_RUN);
        ready_d      = (state_d == ST_RUN);
        error_d      = (state_d == ST_FAIL);
    end

    // State, counters, synchronizer and output registers.
    always_ff @(posedge clk_in1) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            sync_q        <= '0;
            state_q       <= ST_WIZ_RST;
            pulse_cnt_q   <= '0;
            stable_cnt_q  <= '0;
            timeout_cnt_q <= '0;
            retry_q       <= '0;
            wiz_resetn_q  <= 1'b0;
            sys_reset_q   <= 1'b1;
            ready_q       <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            state_q       <= state_d;
            pulse_cnt_q   <= pulse_cnt_d;
            stable_cnt_q  <= stable_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            retry_q       <= retry_d;
            wiz_resetn_q  <= wiz_resetn_d;
            sys_reset_q   <= sys_reset_d;
            ready_q       <= ready_d;
            error_q       <= error_d;
        end
    end

    assign wiz_resetn  = wiz_resetn_q;
    assign sys_reset   = sys_reset_q;
    assign ready       = ready_q;
    assign error       = error_q;
    assign retry_count = retry_q;
    assign state       = state_q;

endmodule

// File: tb/tb_clk_wiz_reset_sequencer.sv
// Bench for clk_wiz_reset_sequencer: directed scenarios plus random lock/soft
// reset traffic, every cycle compared against a duration-based reference model.

module tb_clk_wiz_reset_sequencer;

    localparam int WIZ     = 16;
    localparam int STABLE  = 64;
    localparam int TIMEOUT = 4096;
    localparam int MAXR    = 3;

    logic       clk_in1 = 1'b0;
    logic       reset;
    logic       locked;
    logic       soft_reset_req;
    logic       wiz_resetn;
    logic       sys_reset;
    logic       ready;
    logic       error;
    logic [1:0] retry_count;
    logic [1:0] state;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: phase (0 wizard reset, 1 waiting, 2 running, 3 failed),
    // cycles spent in phase, current run of consecutive visible lock cycles,
    // timeouts so far, and the lock samples still in flight to the FSM.
    int   m_phase;
    int   m_age;
    int   m_run;
    int   m_retry;
    logic lk_q[$];

    always #5 clk_in1 = ~clk_in1;

    clk_wiz_reset_sequencer #(
        .WIZ_RST_CYCLES      (WIZ),
        .LOCK_STABLE_CYCLES  (STABLE),
        .LOCK_TIMEOUT_CYCLES (TIMEOUT),
        .MAX_RETRIES         (MAXR)
    ) dut (
        .clk_in1        (clk_in1),
        .reset          (reset),
        .locked         (locked),
        .soft_reset_req (soft_reset_req),
        .wiz_resetn     (wiz_resetn),
        .sys_reset      (sys_reset),
        .ready          (ready),
        .error          (error),
        .retry_count    (retry_count),
        .state          (state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge with the inputs sampled there.
    task automatic model_edge(input logic r, input logic s, input logic l);
        logic ls;
        if (r) begin
            m_phase = 0; m_age = 0; m_run = 0; m_retry = 0;
            lk_q = {1'b0, 1'b0};
        end else begin
            ls = lk_q[0];
            void'(lk_q.pop_front());
            lk_q.push_back(l);
            if (s) begin
                m_phase = 0; m_age = 0; m_run = 0; m_retry = 0;
            end else begin
                case (m_phase)
                    0: begin
                        m_age++;
                        if (m_age == WIZ) begin
                            m_phase = 1; m_age = 0; m_run = 0;
                        end
                    end
                    1: begin
                        m_age++;
                        m_run = ls ? m_run + 1 : 0;
                        if (m_run == STABLE) begin
                            m_phase = 2; m_retry = 0;
                        end else if (m_age == TIMEOUT) begin
                            if (m_retry == MAXR) begin
                                m_phase = 3;
                            end else begin
                                m_retry++; m_phase = 0; m_age = 0;
                            end
                        end
                    end
                    2: begin
                        if (!ls) begin
                            m_phase = 0; m_age = 0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic compare_model();
        check("state",       32'(state),       32'(m_phase));
        check("wiz_resetn",  32'(wiz_resetn),  32'(m_phase == 1 || m_phase == 2));
        check("sys_reset",   32'(sys_reset),   32'(m_phase != 2));
        check("ready",       32'(ready),       32'(m_phase == 2));
        check("error",       32'(error),       32'(m_phase == 3));
        check("retry_count", 32'(retry_count), 32'(m_retry));
    endtask

    task automatic step(input logic r, input logic s, input logic l);
        reset          = r;
        soft_reset_req = s;
        locked         = l;
        @(posedge clk_in1);
        model_edge(r, s, l);
        #1;
        compare_model();
    endtask

    // Step with a fixed lock level until the selected output event is seen:
    // 0 = sys_reset low, 1 = error high, 2 = ready high. n = limit on expiry.
    task automatic run_until(input logic l, input int which, input int limit, output int n);
        bit done;
        done = 1'b0;
        n = 0;
        while (!done && n < limit) begin
            step(1'b0, 1'b0, l);
            n++;
            case (which)
                0:       done = (sys_reset === 1'b0);
                1:       done = (error === 1'b1);
                default: done = (ready === 1'b1);
            endcase
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 32'(state),       32'd0);
        check({tag, "_wiz"},   32'(wiz_resetn),  32'd0);
        check({tag, "_sys"},   32'(sys_reset),   32'd1);
        check({tag, "_ready"}, 32'(ready),       32'd0);
        check({tag, "_error"}, 32'(error),       32'd0);
        check({tag, "_retry"}, 32'(retry_count), 32'd0);
    endtask

    initial begin
        int n;
        reset          = 1'b1;
        soft_reset_req = 1'b0;
        locked         = 1'b0;

        // Nominal bring-up with lock tied high.
        repeat (3) step(1'b1, 1'b0, 1'b1);
        check_reset_values("por");
        run_until(1'b1, 0, 200, n);
        check("nominal_release_cycles", 32'(n), 32'd80);
        check("nominal_ready", 32'(ready), 32'd1);
        check("nominal_retry", 32'(retry_count), 32'd0);

        // One-cycle lock drop while running.
        step(1'b0, 1'b0, 1'b0);
        check("loss_edge1_sys", 32'(sys_reset), 32'd0);
        step(1'b0, 1'b0, 1'b1);
        check("loss_edge2_sys", 32'(sys_reset), 32'd0);
        step(1'b0, 1'b0, 1'b1);
        check("loss_edge3_sys", 32'(sys_reset), 32'd1);
        check("loss_edge3_wiz", 32'(wiz_resetn), 32'd0);
        run_until(1'b1, 0, 200, n);
        check("loss_rerelease_cycles", 32'(n), 32'd80);
        check("loss_retry", 32'(retry_count), 32'd0);

        // Lock glitch during WAIT_LOCK restarts the stable count.
        repeat (2) step(1'b1, 1'b0, 1'b0);
        repeat (WIZ) step(1'b0, 1'b0, 1'b0);
        check("glitch_in_wait", 32'(state), 32'd1);
        repeat (40) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        run_until(1'b1, 2, 200, n);
        check("glitch_release_cycles", 32'(n), 32'd66);

        // Stable completion on the last timeout cycle: lock wins.
        repeat (2) step(1'b1, 1'b0, 1'b0);
        repeat (WIZ) step(1'b0, 1'b0, 1'b0);
        repeat (TIMEOUT - 66) step(1'b0, 1'b0, 1'b0);
        repeat (66) step(1'b0, 1'b0, 1'b1);
        check("tie_state", 32'(state), 32'd2);
        check("tie_retry", 32'(retry_count), 32'd0);

        // One cycle too late: the timeout fires and a retry starts.
        repeat (2) step(1'b1, 1'b0, 1'b0);
        repeat (WIZ) step(1'b0, 1'b0, 1'b0);
        repeat (TIMEOUT - 65) step(1'b0, 1'b0, 1'b0);
        repeat (65) step(1'b0, 1'b0, 1'b1);
        check("late_state", 32'(state), 32'd0);
        check("late_retry", 32'(retry_count), 32'd1);

        // No lock at all: four attempts then sticky FAIL.
        repeat (2) step(1'b1, 1'b0, 1'b0);
        run_until(1'b0, 1, 20000, n);
        check("fail_cycles", 32'(n), 32'((MAXR + 1) * (WIZ + TIMEOUT)));
        check("fail_state", 32'(state), 32'd3);
        check("fail_wiz", 32'(wiz_resetn), 32'd0);
        check("fail_retry", 32'(retry_count), 32'd3);
        repeat (20) step(1'b0, 1'b0, 1'b1);
        check("fail_sticky", 32'(error), 32'd1);
        step(1'b0, 1'b1, 1'b1);
        check("soft_exit_state", 32'(state), 32'd0);
        check("soft_exit_error", 32'(error), 32'd0);
        check("soft_exit_retry", 32'(retry_count), 32'd0);
        run_until(1'b1, 2, 200, n);
        check("soft_release_cycles", 32'(n), 32'd80);

        // Reset and soft request together while running.
        step(1'b1, 1'b1, 1'b1);
        check_reset_values("rst_soft");
        run_until(1'b1, 0, 200, n);
        check("rst_soft_release_cycles", 32'(n), 32'd80);

        // Random lock drops, soft requests and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 999) == 0),
                 ($urandom_range(0, 399) == 0),
                 ($urandom_range(0, 99) >= 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
